// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module  : counter
// Brief   : Enabled up-counter, wraps modulo 2^WIDTH, synchronous reset.
// Revision: 1.0 - initial release
// ============================================================================
module counter #(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0,
    parameter int STEP        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] c_reset_value = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] c_step        = WIDTH'(STEP);

    logic [WIDTH-1:0] r_count;

    // Reset outranks enable; the WIDTH-bit sum drops the carry so the count wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_reset_value;
        end else if (ena) begin
            r_count <= r_count + c_step;
        end
    end

    assign result = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_counter
// Brief   : Scoreboard-driven self-checking bench for counter (WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_counter;

    logic       clk;
    logic       reset;
    logic       ena;
    logic [7:0] result;

    int n_checks;
    int n_errors;

    logic [7:0] exp_q[$];

    counter #(
        .WIDTH      (8),
        .RESET_VALUE(0),
        .STEP       (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // Drive inputs, queue the expected count, advance past one rising edge.
    task automatic run_edge(input logic r, input logic e, input logic [7:0] exp);
        reset = r;
        ena   = e;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        run_edge(1'b1, 1'b0, 8'd0);
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_errors++;
            $display("FAIL reset_first_edge: result=%0d expected=%0d", result, exp);
        end
    endtask

    task automatic test_count_hold();
        logic       r_tab[5] = '{0, 0, 0, 0, 0};
        logic       e_tab[5] = '{1, 1, 1, 1, 0};
        logic [7:0] x_tab[5] = '{1, 2, 3, 4, 4};
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) begin
            run_edge(r_tab[i], e_tab[i], x_tab[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_errors++;
                $display("FAIL count_hold[%0d]: result=%0d expected=%0d", i, result, exp);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic       e_tab[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        logic [7:0] x_tab[10] = '{5, 6, 7, 7, 8, 9, 10, 11, 12, 13};
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) begin
            run_edge(1'b0, e_tab[i], x_tab[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_errors++;
                $display("FAIL pause_resume[%0d]: result=%0d expected=%0d", i, result, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        logic [7:0] tail[3] = '{255, 0, 1};
        // Climb from 13 to 254 one enabled edge at a time.
        for (int v = 14; v <= 254; v++) begin
            run_edge(1'b0, 1'b1, 8'(v));
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_errors++;
                $display("FAIL preload[%0d]: result=%0d expected=%0d", v, result, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            run_edge(1'b0, 1'b1, tail[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_errors++;
                $display("FAIL wrap[%0d]: result=%0d expected=%0d", i, result, exp);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic       r_tab[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
        logic       e_tab[8] = '{0, 1, 1, 1, 1, 1, 1, 1};
        logic [7:0] x_tab[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) begin
            run_edge(r_tab[i], e_tab[i], x_tab[i]);
            exp = exp_q.pop_front();
            n_checks++;
            if (result !== exp) begin
                n_errors++;
                $display("FAIL reset_priority[%0d]: result=%0d expected=%0d", i, result, exp);
            end
        end
    endtask

    task automatic test_between_edges();
        logic [7:0] exp;
        // Count sits at 1; pulse reset and ena between edges only.
        ena = 1'b0;
        exp_q.push_back(8'd1);
        #2 reset = 1'b1;
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_errors++;
            $display("FAIL reset_no_edge: result=%0d expected=%0d", result, exp);
        end
        #1 reset = 1'b0;
        ena = 1'b1;
        exp_q.push_back(8'd1);
        #1;
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_errors++;
            $display("FAIL ena_no_edge: result=%0d expected=%0d", result, exp);
        end
        #1 ena = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(8'd1);
        exp = exp_q.pop_front();
        n_checks++;
        if (result !== exp) begin
            n_errors++;
            $display("FAIL glitch_next_edge: result=%0d expected=%0d", result, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        ena      = 1'b0;
        test_reset();
        test_count_hold();
        test_pause_resume();
        test_wrap();
        test_reset_priority();
        test_between_edges();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: entries=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
